bresenham_stepper: RTL
======================

Name: bresenham_stepper

Overview:
- Downstream consumer of the angle-reduction stage in the Bresenham ray path.
- Accepts one ray command per handshake: start cell, octant-0 run lengths, and the three flip flags from angle reduction.
- Walks the ray with integer Bresenham in the first octant, maps each step back to the true octant via the flags, and streams grid cells one per cycle over a valid/ready interface to the map-update logic.

Parameters:
COORD_W, 16, width of signed two's-complement cell coordinates
LEN_W, 16, width of unsigned major/minor run lengths

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
start_x  in  COORD_W  signed start cell x
start_y  in  COORD_W  signed start cell y
delta_major  in  LEN_W  octant-0 run along major axis (u)
delta_minor  in  LEN_W  octant-0 run along minor axis (v), legal range 0..delta_major
flip_x  in  1  negate x offset
flip_y  in  1  negate y offset
flip_identity  in  1  swap axes (major becomes y)
cell_valid  out  1  cell_x/cell_y valid
cell_ready  in  1  consumer accepts cell
cell_x  out  COORD_W  signed cell x
cell_y  out  COORD_W  signed cell y
cell_last  out  1  marks final cell of ray
busy  out  1  high in RUN

Behaviour:
- Reset (rst_n low at clock edge): state IDLE; cmd_ready=1, cell_valid=0, cell_last=0, busy=0, cell_x=cell_y=0; internal u, v, err and count cleared. Reset mid-ray discards the ray, with no further cells.
- FSM IDLE -> RUN on cmd_valid && cmd_ready.
  - Capture all inputs.
  - Clamp minor to min(delta_minor, delta_major).
  - Set u=0, v=0, err = 2*minor - major (signed, LEN_W+2 bits), remaining = major.
- Latency: command accepted at edge N; cell_valid=1 from cycle N+1 with the start cell.
- In RUN, a cell transfers on cell_valid && cell_ready. On transfer:
  - If cell_last: go to IDLE, cell_valid=0.
  - Else u+=1; if err>0 then v+=1 and err += 2*minor - 2*major, else err += 2*minor; remaining -= 1.
  - The next cell is presented the following cycle, giving 1 cell/cycle throughput under continuous ready.
- Backpressure: while cell_valid && !cell_ready, cell_x, cell_y, cell_last and internal state hold unchanged.
- Output mapping is registered and computed from the updated (u, v):
  - (dx, dy) = flip_identity ? (v, u) : (u, v).
  - If flip_x, dx = -dx. If flip_y, dy = -dy.
  - cell_x = start_x + dx, cell_y = start_y + dy.
- cell_last=1 exactly when remaining==0 for the presented cell. A ray emits major+1 cells.
- delta_major=0: a single cell (the start cell) with cell_last=1.
- Coordinate arithmetic wraps modulo 2^COORD_W, with no saturation. u and v are sized LEN_W+1.
- cmd_valid in RUN is ignored (cmd_ready=0); the command must be held until accepted. A new command is accepted at the earliest on the cycle after the last-cell transfer.
- cell_valid never asserts in IDLE.

Test Plan:
- No flips, start (0,0), major=4, minor=2, cell_ready=1 -> cells (0,0),(1,0),(2,1),(3,1),(4,2); last only on (4,2); first valid one cycle after accept; cmd_ready returns 1 after last.
- All three flips set, start (10,10), major=4, minor=2 -> cells (10,10),(10,9),(9,8),(9,7),(8,6).
- Same as the first scenario with cell_ready low on cycles 2-4 of the ray -> outputs frozen while stalled; identical sequence; no skipped or duplicated cells.
- major=0, minor=0, start (-5,7) -> exactly one cell (-5,7) with cell_last=1; back in IDLE the next cycle. Also major=3, minor=9 -> treated as minor=3, cells (0,0),(1,1),(2,2),(3,3).
- Wrap: start_x=32767, start_y=0, major=2, minor=0 -> cells x=32767, -32768, -32767, y=0 throughout.
- Reset: assert rst_n=0 after the 2nd cell of a 10-cell ray -> next cycle cell_valid=0, busy=0, cmd_ready=1, outputs zero; a fresh command then runs correctly from its start cell.

Source files
------------

// File: rtl/bresenham_stepper.sv
// bresenham_stepper: walks an octant-0 Bresenham ray, maps each step back to its true octant and streams grid cells.
module bresenham_stepper #(
  parameter int COORD_W = 16,
  parameter int LEN_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic signed [COORD_W-1:0] start_x,
  input  logic signed [COORD_W-1:0] start_y,
  input  logic [LEN_W-1:0]          delta_major,
  input  logic [LEN_W-1:0]          delta_minor,
  input  logic                      flip_x,
  input  logic                      flip_y,
  input  logic                      flip_identity,
  output logic                      cell_valid,
  input  logic                      cell_ready,
  output logic signed [COORD_W-1:0] cell_x,
  output logic signed [COORD_W-1:0] cell_y,
  output logic                      cell_last,
  output logic                      busy
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [COORD_W-1:0] sx, sy, dx, dy;
  logic fx, fy, fi, accept, fire, step_v;
  logic [LEN_W-1:0] minor, major, rem, mn;
  logic [LEN_W:0] u, v, nu, nv;
  logic signed [LEN_W+1:0] err, err0, err_nx, two_min, two_maj;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && cmd_valid) state_nx = RUN;
    else if (state == RUN && cell_ready && cell_last) state_nx = IDLE;
  end
  assign cmd_ready  = state == IDLE;
  assign cell_valid = state == RUN;
  assign busy       = state == RUN;
  assign accept     = cmd_valid && cmd_ready;
  assign fire       = cell_valid && cell_ready;
  assign mn         = delta_minor > delta_major ? delta_major : delta_minor;
  assign err0       = $signed({1'b0, mn, 1'b0}) - $signed({2'b00, delta_major});
  assign two_min    = $signed({1'b0, minor, 1'b0});
  assign two_maj    = $signed({1'b0, major, 1'b0});
  // err > 0 means the line has crossed the midpoint; ties stay on the current minor row
  assign step_v     = !err[LEN_W+1] && |err;
  assign err_nx     = step_v ? err + two_min - two_maj : err + two_min;
  assign nu         = u + (LEN_W+1)'(1);
  assign nv         = step_v ? v + (LEN_W+1)'(1) : v;
  always_comb begin
    dx = COORD_W'(fi ? nv : nu);
    dy = COORD_W'(fi ? nu : nv);
    dx = fx ? -dx : dx;
    dy = fy ? -dy : dy;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      {sx, sy, fx, fy, fi, minor, major, rem, u, v, err} <= '0;
      cell_x <= '0;
      cell_y <= '0;
      cell_last <= 1'b0;
    end else if (accept) begin
      sx <= start_x;
      sy <= start_y;
      fx <= flip_x;
      fy <= flip_y;
      fi <= flip_identity;
      minor <= mn;
      major <= delta_major;
      rem <= delta_major;
      u <= '0;
      v <= '0;
      err <= err0;
      cell_x <= start_x;
      cell_y <= start_y;
      cell_last <= delta_major == '0;
    end else if (fire && !cell_last) begin
      u <= nu;
      v <= nv;
      err <= err_nx;
      rem <= rem - LEN_W'(1);
      cell_x <= sx + dx;
      cell_y <= sy + dy;
      cell_last <= rem == LEN_W'(1);
    end
endmodule
